// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, times mult/div with a
// latency counter and stalls D-stage HI/LO instructions while one is in flight.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_md_use,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] E_md_rdata
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] res_hi, res_lo;
  logic        is_mul;

  assign prod_s = 64'($signed(E_A)) * 64'($signed(E_B));
  assign prod_u = {32'h0, E_A} * {32'h0, E_B};
  assign is_mul = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);

  // Result is computed in the issue cycle; the counter only models latency.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (E_md_op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (E_B == '0) begin
          res_lo = '1;
          res_hi = E_A;
        end else if (E_A == 32'h8000_0000 && E_B == '1) begin
          res_lo = 32'h8000_0000;
          res_hi = '0;
        end else begin
          res_lo = 32'($signed(E_A) / $signed(E_B));
          res_hi = 32'($signed(E_A) % $signed(E_B));
        end
      end
      OP_DIVU: begin
        if (E_B == '0) begin
          res_lo = '1;
          res_hi = E_A;
        end else begin
          res_lo = E_A / E_B;
          res_hi = E_A % E_B;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

  assign start = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && (state_q == S_IDLE);
  assign busy  = (state_q == S_BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = is_mul ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
          state_d   = S_BUSY;
        end else if (E_md_op == OP_MTHI) begin
          hi_d = E_A;
        end else if (E_md_op == OP_MTLO) begin
          lo_d = E_A;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign md_stall   = D_md_use & (start | busy);
  assign E_md_rdata = (E_md_op == OP_MFHI) ? hi_q :
                      (E_md_op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: vector table of mult/div ops with a
// result scoreboard, plus hand sequences for mt*, ignored ops and async reset.
module tb_md_ctrl;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk;
  logic        rst_n;
  logic        D_md_use;
  logic [3:0]  E_md_op;
  logic [31:0] E_A, E_B;
  logic        start, busy, md_stall;
  logic [31:0] hi, lo, E_md_rdata;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D_md_use  (D_md_use),
    .E_md_op   (E_md_op),
    .E_A       (E_A),
    .E_B       (E_B),
    .start     (start),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo),
    .E_md_rdata(E_md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int unsigned n;
    logic [3:0]  junk;
    logic        use_d;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vt[11];
  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int unsigned n,
                        input logic [3:0] junk, input logic use_d);
    res_t r;
    @(posedge clk); #1;
    E_md_op = op; E_A = a; E_B = b; D_md_use = use_d;
    @(negedge clk);
    chk("start_t0", start, 1);
    chk("busy_t0", busy, 0);
    chk("stall_t0", md_stall, use_d);
    sb.push_back('{hi: eh, lo: el});
    for (int unsigned j = 1; j <= n + 1; j++) begin
      @(posedge clk); #1;
      if (j <= n) begin
        E_md_op = junk; E_A = 32'hDEAD; E_B = 32'h3;
      end else begin
        E_md_op = '0;
      end
      @(negedge clk);
      chk("busy", busy, (j <= n) ? 32'd1 : 32'd0);
      chk("start_busy", start, 0);
      chk("stall", md_stall, (use_d && j <= n) ? 32'd1 : 32'd0);
      if (j <= n) begin
        chk("hi_hold", hi, mdl_hi);
        chk("lo_hold", lo, mdl_lo);
      end else if (sb.size() == 0) begin
        chk("sb_empty_pop", 1, 0);
      end else begin
        r = sb.pop_front();
        chk("hi_commit", hi, r.hi);
        chk("lo_commit", lo, r.lo);
      end
    end
    mdl_hi = eh; mdl_lo = el;
    D_md_use = 1'b0;
    @(posedge clk); #1; E_md_op = 4'd7;
    @(negedge clk); chk("mfhi", E_md_rdata, eh);
    @(posedge clk); #1; E_md_op = 4'd8;
    @(negedge clk); chk("mflo", E_md_rdata, el);
    @(posedge clk); #1; E_md_op = '0;
  endtask

  task automatic run_mt(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    E_md_op = op; E_A = a;
    @(negedge clk);
    chk("mt_start", start, 0);
    chk("mt_busy", busy, 0);
    if (op == 4'd5) mdl_hi = a; else mdl_lo = a;
    @(posedge clk); #1; E_md_op = (op == 4'd5) ? 4'd7 : 4'd8; E_A = 32'h0BAD;
    @(negedge clk);
    chk("mt_hi", hi, mdl_hi);
    chk("mt_lo", lo, mdl_lo);
    chk("mt_rdata", E_md_rdata, a);
    @(posedge clk); #1; E_md_op = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC, 4'd0, 1'b0};
    vt[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC, 4'd0, 1'b1};
    vt[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, 4'd1, 1'b0};
    vt[3]  = '{4'd4, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, DC, 4'd0, 1'b1};
    vt[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC, 4'd3, 1'b0};
    vt[5]  = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC, 4'd6, 1'b1};
    vt[6]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC, 4'd0, 1'b0};
    vt[7]  = '{4'd3, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, DC, 4'd2, 1'b1};
    vt[8]  = '{4'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC, 4'd4, 1'b0};
    vt[9]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC, 4'd0, 1'b1};
    vt[10] = '{4'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MC, 4'd5, 1'b0};

    rst_n = 1'b0; D_md_use = 1'b0; E_md_op = '0; E_A = '0; E_B = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_start", start, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, vt[i].n, vt[i].junk, vt[i].use_d);

    run_mt(4'd6, 32'h1234);
    run_mt(4'd5, 32'h5555);

    // mthi during BUSY must be ignored
    run_op(4'd1, 32'd3, 32'd4, 32'd0, 32'd12, MC, 4'd5, 1'b0);
    run_mt(4'd5, 32'hABCD);

    // async reset in the middle of a divide
    @(posedge clk); #1; E_md_op = 4'd3; E_A = 32'd100; E_B = 32'd3;
    @(negedge clk); chk("rd_start", start, 1);
    @(posedge clk); #1; E_md_op = '0;
    @(posedge clk); @(posedge clk); #2;
    chk("rd_busy_pre", busy, 1);
    rst_n = 1'b0; #1;
    chk("rd_busy", busy, 0);
    chk("rd_hi", hi, 0);
    chk("rd_lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rd_idle", busy, 0);
    end
    chk("rd_hi_end", hi, 0);
    chk("rd_lo_end", lo, 0);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
